// File: rtl/seq_magnitude_comparator_pkg.sv
// seq_magnitude_comparator_pkg: shared state encoding and result codes for the sequential comparator
package seq_magnitude_comparator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  // Result codes packed as {less, equal, great}
  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;
endpackage

// File: rtl/seq_magnitude_comparator_cell.sv
// digit_compare_cell: one MSB-first cascade step; the verdict freezes once a digit differs
module digit_compare_cell #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             lt_out,
  output logic             eq_out,
  output logic             gt_out
);
  always_comb begin
    lt_out = eq_in ? (da < db) : lt_in;
    gt_out = eq_in ? (da > db) : gt_in;
    eq_out = eq_in && (da == db);
  end
endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first magnitude compare, DIGIT bits per cycle
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             less_out,
  output logic             equal_out,
  output logic             great_out
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic             rl_q, rl_d, re_q, re_d, rg_q, rg_d;
  logic             c_lt, c_eq, c_gt, last;
  digit_compare_cell #(.DIGIT(DIGIT)) u_cell (
    .da(sa_q[WIDTH-1 -: DIGIT]),
    .db(sb_q[WIDTH-1 -: DIGIT]),
    .lt_in(lt_q),
    .eq_in(eq_q),
    .gt_in(gt_q),
    .lt_out(c_lt),
    .eq_out(c_eq),
    .gt_out(c_gt)
  );
  assign last = (cnt_q == CW'(N - 1)) || (EARLY_EXIT && !c_eq);
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    rl_d    = rl_q;
    re_d    = re_q;
    rg_d    = rg_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        // Flipping the sign bit maps two's-complement order onto unsigned order
        sa_d    = signed_mode ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
        sb_d    = signed_mode ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
        cnt_d   = '0;
        {lt_d, eq_d, gt_d} = 3'b010;
        {rl_d, re_d, rg_d} = 3'b000;
      end
      RUN: begin
        sa_d  = sa_q << DIGIT;
        sb_d  = sb_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
        {lt_d, eq_d, gt_d} = {c_lt, c_eq, c_gt};
        if (last) begin
          state_d = DONE;
          {rl_d, re_d, rg_d} = {c_lt, c_eq, c_gt};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b1;
      gt_q    <= 1'b0;
      rl_q    <= 1'b0;
      re_q    <= 1'b0;
      rg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      rl_q    <= rl_d;
      re_q    <= re_d;
      rg_q    <= rg_d;
    end
  end
  assign ready     = state_q == IDLE;
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign less_out  = rl_q;
  assign equal_out = re_q;
  assign great_out = rg_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: directed checks on three configurations driven in parallel
module tb_seq_magnitude_comparator;
  import seq_magnitude_comparator_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sm = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] rdy, bsy, dn, lt, eq, gt;
  int         compared = 0;
  int         mismatched = 0;
  always #5 clk = ~clk;
  // Instance 0: DIGIT=1 early exit, 1: DIGIT=1 full run, 2: DIGIT=4 early exit
  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
    .less_out(lt[0]), .equal_out(eq[0]), .great_out(gt[0]));
  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
    .less_out(lt[1]), .equal_out(eq[1]), .great_out(gt[1]));
  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(1'b1)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]),
    .less_out(lt[2]), .equal_out(eq[2]), .great_out(gt[2]));

  task automatic wait_idle();
    int n = 0;
    while (rdy !== 3'b111 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (rdy !== 3'b111) begin
      mismatched++;
      $display("FAIL idle_timeout: ready=%b required 111", rdy);
    end
  endtask

  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input logic s,
                         input int idx, input int exp_lat, input logic [2:0] exp_res,
                         input string nm);
    int lat = 0;
    logic [2:0] r;
    @(negedge clk);
    a = av; b = bv; sm = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; sm = ~s;
    compared++;
    if (bsy[idx] !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_busy: busy=%b required 1", nm, bsy[idx]);
    end
    while (dn[idx] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = {lt[idx], eq[idx], gt[idx]};
    compared++;
    if (lat != exp_lat) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d cycles required %0d", nm, lat, exp_lat);
    end
    compared++;
    if (r !== exp_res) begin
      mismatched++;
      $display("FAIL %s_result: lt/eq/gt=%b required %b", nm, r, exp_res);
    end
    @(posedge clk); #1;
    compared++;
    if (dn[idx] !== 1'b0 || {lt[idx], eq[idx], gt[idx]} !== exp_res) begin
      mismatched++;
      $display("FAIL %s_hold: done=%b flags=%b required done 0 flags %b",
               nm, dn[idx], {lt[idx], eq[idx], gt[idx]}, exp_res);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (rdy !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b required 111/000/000", rdy, bsy, dn);
    end
    compared++;
    if ({lt, eq, gt} !== 9'd0) begin
      mismatched++;
      $display("FAIL reset_flags: lt=%b eq=%b gt=%b required all 0", lt, eq, gt);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_cmp(8'h5A, 8'h5A, 1'b0, 0, 8, RES_EQ, "eq_5a");
    run_cmp(8'h12, 8'h13, 1'b0, 0, 8, RES_LT, "lsb_diff");
    run_cmp(8'h80, 8'h7F, 1'b0, 1, 8, RES_GT, "full_run");
  endtask

  task automatic test_early_exit();
    run_cmp(8'h80, 8'h7F, 1'b0, 0, 1, RES_GT, "ee_unsigned");
    run_cmp(8'h80, 8'h7F, 1'b1, 0, 1, RES_LT, "ee_signed");
    run_cmp(8'h80, 8'h7F, 1'b1, 1, 8, RES_LT, "full_signed");
  endtask

  task automatic test_digit4();
    run_cmp(8'hF3, 8'hF5, 1'b0, 2, 2, RES_LT, "d4_lo");
    run_cmp(8'hFF, 8'h01, 1'b1, 2, 1, RES_LT, "d4_signed");
    run_cmp(8'h5A, 8'h5A, 1'b0, 2, 2, RES_EQ, "d4_eq");
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [2:0] r = '0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = (i < 2);
      a = 8'hFF; b = 8'h00;
      @(posedge clk); #1;
      if (dn[0] === 1'b1) begin
        pulses++;
        r = {lt[0], eq[0], gt[0]};
      end
    end
    compared++;
    if (pulses != 1) begin
      mismatched++;
      $display("FAIL ignore_pulses: got %0d done pulses required 1", pulses);
    end
    compared++;
    if (r !== RES_LT) begin
      mismatched++;
      $display("FAIL ignore_result: flags=%b required %b", r, RES_LT);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    a = 8'h5A; b = 8'h5A; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (rdy !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000 || {lt, eq, gt} !== 9'd0) begin
      mismatched++;
      $display("FAIL async_reset: ready=%b busy=%b done=%b flags=%b required 111/000/000/0",
               rdy, bsy, dn, {lt, eq, gt});
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dn !== 3'b000) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL reset_no_done: got %0d done cycles required 0", pulses);
    end
    run_cmp(8'h03, 8'h01, 1'b0, 0, 7, RES_GT, "after_reset");
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    @(negedge clk);
    a = 8'h80; b = 8'h7F; sm = 1'b0; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (dn[0] === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    start = 1'b0;
    compared++;
    if (first != 2) begin
      mismatched++;
      $display("FAIL b2b_first: first done at cycle %0d required 2", first);
    end
    compared++;
    if (second - first != 3) begin
      mismatched++;
      $display("FAIL b2b_throughput: gap %0d cycles required 3", second - first);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_early_exit();
    test_digit4();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the fixed-width combinational ripple comparator.
- Latches two WIDTH-bit operands on a start handshake and compares them MSB-first, DIGIT bits per cycle.
- Supports unsigned and two's-complement modes, with optional early exit on the first differing digit.
- Used where wide compares must not sit on a long combinational cascade (datapath flag units, sort/select engines).

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- DIGIT, 1, bits compared per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT digits.
- EARLY_EXIT, 1, 1 = finish at the first differing digit; 0 = always run all N digits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- signed_mode  in  1  sampled with start; 1 = two's-complement compare.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- less_out  out  1  A < B.
- equal_out  out  1  A == B.
- great_out  out  1  A > B.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; ready=1, busy=0, done=0; less_out=equal_out=great_out=0; shift registers and digit counter cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after digit N, or after the first unequal digit when EARLY_EXIT=1.
  - DONE -> IDLE unconditionally after one cycle.
- Accept (IDLE, start=1 at edge T):
  - Load shift_a=a and shift_b=b.
  - If signed_mode=1, invert the MSB of both (offset-binary mapping), so the unsigned compare yields the signed order.
  - Internal cascade initialises to lt=0, eq=1, gt=0; digit counter=0.
- RUN, each cycle: compare the top DIGIT bits of shift_a and shift_b.
  - Cascade update only while eq=1: lt=(da<db), gt=(da>db), eq=(da==db).
  - Once eq=0, lt and gt are frozen.
  - Shift both registers left by DIGIT; increment the counter.
- Latency: RUN occupies edges T+1..T+k, where k=N, or the index of the first differing digit if EARLY_EXIT=1. done=1 during the cycle after edge T+k+1 (the DONE state).
- Equal operands always take the full N cycles.
- Results: less_out/equal_out/great_out update on entry to DONE and hold until the next accepted start, then clear to 0 while RUN. Exactly one result bit is high in DONE.
- start while busy or in DONE is ignored. Operand changes after acceptance have no effect.
- start held continuously: a new compare is accepted on the first IDLE cycle after DONE (throughput = k+2 cycles).
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all outputs at reset values. No done pulse for the aborted operation.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Result-code constants RES_LT/RES_EQ/RES_GT for benches.
- One natural sub-module: digit_compare_cell.
  - Combinational, parametrised by DIGIT.
  - Inputs: da, db, lt_in, eq_in, gt_in. Outputs: lt_out, eq_out, gt_out.
  - Implements the cascade update above.
  - Instantiated once in the top; the top owns the FSM, counter, shift registers and result registers.

Test Plan:
- WIDTH=8, DIGIT=1, unsigned, a=8'h5A, b=8'h5A, start at T -> busy T+1..T+8, done at T+9, equal_out=1, others 0.
- Unsigned, EARLY_EXIT=1, a=8'h80, b=8'h7F -> great_out=1, done at T+2. Repeat with signed_mode=1 -> less_out=1 (-128 < 127), done at T+2.
- Unsigned, a=8'h12, b=8'h13 (differs only at bit 0) -> less_out=1, done at T+9. Same with EARLY_EXIT=0 and a=8'h80, b=8'h7F -> done at T+9, great_out=1.
- DIGIT=4, a=8'hF3, b=8'hF5 -> less_out=1, done at T+3. Signed a=8'hFF, b=8'h01 -> less_out=1 (-1 < 1), done at T+2.
- Start a=8'h10, b=8'h20. During RUN assert start with a=8'hFF, b=8'h00 -> second request ignored, result less_out=1, and only one done pulse.
- Assert rst for one cycle at T+4 of a run -> ready=1 and all flags 0 immediately, no done. A subsequent start with a=8'h03, b=8'h01 -> great_out=1.
